// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide unit for the M-extension funct3 ops.
// Define MULDIV_FAST_MUL_EN to compute all multiplies with a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opr_1_i,
  input  logic [XLEN-1:0] opr_2_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic              neg1_q, neg2_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   res_q;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Request decode: operand signedness, magnitudes and the special divide cases
  logic            sgn1, sgn2, n1, n2;
  logic            div_zero, div_ovf, direct;
  logic [XLEN-1:0] mag1, mag2, direct_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;

  always_comb begin
    fast_a = sgn1 ? $signed({{XLEN{opr_1_i[XLEN-1]}}, opr_1_i}) : $signed({{XLEN{1'b0}}, opr_1_i});
    fast_b = sgn2 ? $signed({{XLEN{opr_2_i[XLEN-1]}}, opr_2_i}) : $signed({{XLEN{1'b0}}, opr_2_i});
    fast_p = fast_a * fast_b;
  end
`endif

  always_comb begin
    sgn1     = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    sgn2     = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    n1       = sgn1 && opr_1_i[XLEN-1];
    n2       = sgn2 && opr_2_i[XLEN-1];
    mag1     = neg_if(opr_1_i, n1);
    mag2     = neg_if(opr_2_i, n2);
    div_zero = op_i[2] && (opr_2_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (opr_1_i == MIN_NEG) && (opr_2_i == '1);
    direct     = div_zero || div_ovf;
    direct_res = '0;
    if (div_zero) begin
      direct_res = op_i[1] ? opr_1_i : '1;
    end else if (div_ovf) begin
      direct_res = op_i[1] ? '0 : opr_1_i;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!op_i[2]) begin
      direct     = 1'b1;
      direct_res = (op_i == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] step_nxt, mul_p;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      step_nxt = div_ge ? {div_diff, prod_q[XLEN-2:0], 1'b1} : {prod_q[2*XLEN-2:0], 1'b0};
    end else begin
      step_nxt = {mul_sum, prod_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection once the magnitude loop has finished
  always_comb begin
    mul_p = neg2_if(prod_q, neg1_q ^ neg2_q);
    case (op_q)
      OP_MUL:                      fix_res = mul_p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = mul_p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = neg_if(prod_q[XLEN-1:0], neg1_q ^ neg2_q);
      default:                     fix_res = neg_if(prod_q[2*XLEN-1:XLEN], neg1_q);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    result_o    = (state_q == DONE) ? res_q : '0;
    case (state_q)
      IDLE: begin
        if (in_valid_i && !kill_i) begin
          accept  = 1'b1;
          state_d = direct ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = kill_i ? IDLE : DONE;
      DONE:    if (kill_i || out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operands are captured on accept and are not needed from the requester afterwards
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q   <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
      opb_q  <= '0;
      res_q  <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      neg1_q <= n1;
      neg2_q <= n2;
      cnt_q  <= '0;
      if (op_i[2]) begin
        prod_q <= {{XLEN{1'b0}}, mag1};
        opb_q  <= mag2;
      end else begin
        prod_q <= {{XLEN{1'b0}}, mag2};
        opb_q  <= mag1;
      end
      if (direct) begin
        res_q <= direct_res;
      end
    end else if (state_q == CALC) begin
      cnt_q  <= cnt_q + 1'b1;
      prod_q <= step_nxt;
    end else if (state_q == FIX) begin
      res_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (XLEN=32); honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [31:0] opr_1_i;
  logic [31:0] opr_2_i;
  logic        kill_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_i       (op_i),
    .opr_1_i    (opr_1_i),
    .opr_2_i    (opr_2_i),
    .kill_i     (kill_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    int          lat;
    int          el;
    logic [31:0] er;
    @(negedge clk_i);
    chk({tag, " in_ready before"}, in_ready_o, 1);
    op_i = op; opr_1_i = a; opr_2_i = b; in_valid_i = 1'b1;
    exp_res_q.push_back(model(op, a, b));
    exp_lat_q.push_back(exp_latency(op, a, b));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    op_i = 3'($urandom); opr_1_i = $urandom; opr_2_i = $urandom;
    chk({tag, " in_ready after accept"}, in_ready_o, 0);
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    chk({tag, " out_valid"}, out_valid_o, 1);
    chk({tag, " result"}, result_o, er);
    chk({tag, " latency"}, lat, el);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_i); #1;
      chk({tag, " stall valid"}, out_valid_o, 1);
      chk({tag, " stall result"}, result_o, er);
      chk({tag, " stall in_ready"}, in_ready_o, 0);
    end
    @(negedge clk_i); out_ready_i = 1'b1;
    @(posedge clk_i); #1; out_ready_i = 1'b0;
    chk({tag, " valid after take"}, out_valid_o, 0);
    chk({tag, " result zero after take"}, result_o, 0);
    chk({tag, " in_ready after take"}, in_ready_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_i = 1'b1; in_valid_i = 1'b0; kill_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; opr_1_i = '0; opr_2_i = '0;
    #1;
    chk("reset in_ready", in_ready_o, 1);
    chk("reset out_valid", out_valid_o, 0);
    chk("reset result", result_o, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_minmin");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 0, "div_neg7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 0, "rem_neg7_2");
    run_op(3'd5, 32'h7, 32'h0, 0, "divu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, "mul_stall");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ones");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ones");
    run_op(3'd7, 32'd100, 32'd7, 0, "remu_100_7");
    run_op(3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, "div_neg_neg");
    run_op(3'd6, 32'h7, 32'hFFFF_FFFE, 0, "rem_pos_neg");
    run_op(3'd6, 32'hDEAD_BEEF, 32'h0, 0, "rem_by0");
    run_op(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu_big");

    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, i % 2, "random");
    end

    // Kill during CALC: back to IDLE on the next edge, no result ever appears
    @(negedge clk_i);
    op_i = 3'd4; opr_1_i = 32'd1000; opr_2_i = 32'd3; in_valid_i = 1'b1;
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk("kill calc in_ready", in_ready_o, 1);
    chk("kill calc out_valid", out_valid_o, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen = 1'b1;
    end
    chk("kill calc no pulse", seen, 0);

    // Kill beats a simultaneous request
    @(negedge clk_i);
    op_i = 3'd5; opr_1_i = 32'd9; opr_2_i = 32'd0; in_valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1; in_valid_i = 1'b0; kill_i = 1'b0;
    chk("kill vs accept in_ready", in_ready_o, 1);
    chk("kill vs accept out_valid", out_valid_o, 0);

    // Kill leaves DONE even without out_ready
    @(negedge clk_i);
    op_i = 3'd5; opr_1_i = 32'd9; opr_2_i = 32'd0; in_valid_i = 1'b1;
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    chk("kill done valid", out_valid_o, 1);
    chk("kill done result", result_o, model(3'd5, 32'd9, 32'd0));
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk("kill done exit valid", out_valid_o, 0);
    chk("kill done exit in_ready", in_ready_o, 1);

    // No bypass: a request present in the DONE-exit cycle is only taken one edge later
    @(negedge clk_i);
    op_i = 3'd7; opr_1_i = 32'h55; opr_2_i = 32'd0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bypass first valid", out_valid_o, 1);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    op_i = 3'd4; opr_1_i = 32'h8000_0000; opr_2_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1; out_ready_i = 1'b0;
    chk("bypass exit in_ready", in_ready_o, 1);
    chk("bypass exit out_valid", out_valid_o, 0);
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    chk("bypass second valid", out_valid_o, 1);
    chk("bypass second result", result_o, model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF));
    @(negedge clk_i); out_ready_i = 1'b1;
    @(posedge clk_i); #1; out_ready_i = 1'b0;

    // Asynchronous reset mid-CALC
    @(negedge clk_i);
    op_i = 3'd0; opr_1_i = 32'd77; opr_2_i = 32'd91; in_valid_i = 1'b1;
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("rst calc in_ready", in_ready_o, 1);
    chk("rst calc out_valid", out_valid_o, 0);
    chk("rst calc result", result_o, 0);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    run_op(3'd5, 32'd12345, 32'd0, 0, "after_reset_calc");

    // Asynchronous reset while holding a result in DONE
    @(negedge clk_i);
    op_i = 3'd7; opr_1_i = 32'hCAFE_F00D; opr_2_i = 32'd0; in_valid_i = 1'b1;
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    chk("rst done pre valid", out_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst done out_valid", out_valid_o, 0);
    chk("rst done result", result_o, 0);
    chk("rst done in_ready", in_ready_o, 1);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0003, 0, "after_reset_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have port clk_i  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid_i  input  1  request valid.
REQ-005 SHALL have port in_ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port op_i  input  3  funct3 of the M extension: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port opr_1_i  input  XLEN  rs1 operand.
REQ-008 SHALL have port opr_2_i  input  XLEN  rs2 operand.
REQ-009 SHALL have port kill_i  input  1  pipeline flush; cancels the in-flight request.
REQ-010 SHALL have port out_valid_o  output  1  result valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer takes the result.
REQ-012 SHALL have port result_o  output  XLEN  result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-014 SHALL accept a request on a rising edge with in_valid_i & in_ready_o & !kill_i, capturing op_i, opr_1_i and opr_2_i; operands need not be held after acceptance.
REQ-015 SHALL, for a normal operation, go IDLE->CALC, spend exactly XLEN cycles in CALC (one radix-2 step per cycle, iteration counter 0..XLEN-1), then 1 cycle in FIX (sign correction/selection), then DONE; out_valid_o rises XLEN+2 cycles after the accept edge.
REQ-016 SHALL compute MUL as the low XLEN bits of the product and MULH/MULHSU/MULHU as the high XLEN bits of the 2*XLEN-bit signed*signed, signed*unsigned and unsigned*unsigned products respectively.
REQ-017 SHALL implement DIV/REM signed, truncating toward zero, with the remainder taking the sign of the dividend; DIVU/REMU SHALL be unsigned.
REQ-018 SHALL, when divisor = 0, go IDLE->DONE directly (latency 1) with DIV/DIVU = all ones and REM/REMU = opr_1.
REQ-019 SHALL, on signed overflow (opr_1 = most negative value, opr_2 = all ones), go IDLE->DONE directly with DIV = opr_1 and REM = 0.
REQ-020 SHALL hold result_o and out_valid_o stable in DONE until out_ready_i is high on a rising edge, then return to IDLE.
REQ-021 SHALL not accept a new request in the DONE-exit cycle (no bypass); a new accept is possible no earlier than the cycle after returning to IDLE.
REQ-022 SHALL, when kill_i is high on a rising edge in any state, go to IDLE with no out_valid_o pulse; kill_i takes priority over accept and over the DONE handshake.
REQ-023 SHALL drive result_o = 0 whenever out_valid_o is low.

Reset
REQ-024 SHALL, on rst_i high, asynchronously force state IDLE, counter 0, all datapath registers 0, out_valid_o = 0, result_o = 0, in_ready_o = 1, including mid-CALC.
REQ-025 SHALL accept the first request on the first rising edge after rst_i deasserts.

Configuration
REQ-026 SHALL honour macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU are computed by a single-cycle combinational multiplier and go IDLE->DONE (latency 1), with divides unchanged; when undefined, all multiplies use the iterative CALC/FIX path of REQ-015.

Verification (XLEN=32, macro undefined unless stated)
REQ-027 SHALL cover: MULH 0x80000000 * 0x80000000 -> result 0x40000000, out_valid 34 cycles after accept.
REQ-028 SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at latency 1.
REQ-029 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 at latency 1.
REQ-030 SHALL cover: out_ready_i held low for 5 cycles in DONE -> result_o and out_valid_o stable; in_ready_o low throughout.
REQ-031 SHALL cover: kill_i at CALC cycle 10 -> IDLE next edge, no out_valid pulse; rst_i mid-CALC -> all outputs at reset values immediately, without waiting for a clock edge.
REQ-032 SHALL cover: with MULDIV_FAST_MUL_EN defined, MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE at latency 1.
